// File: rtl/upsample2x_addr_ctrl.sv
// Address/mode sequencer for the 2x upsampling datapath: loads the input buffer,
// then walks every pixel of every channel and emits read/write addresses and a border code.
module upsample2x_addr_ctrl #(
  parameter int IN_W     = 4,
  parameter int IN_H     = 4,
  parameter int CHANNELS = 1,
  parameter int AIN_W    = 6,
  parameter int AOUT_W   = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic                                          abort,
  input  logic                                          load_valid,
  input  logic                                          out_ready,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          en_write_in,
  output logic                                          en_write_out,
  output logic [AIN_W-1:0]                              addr_input,
  output logic [AOUT_W-1:0]                             addr_output,
  output logic [3:0]                                    write_mode,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ch_idx
);

  localparam int N  = IN_W * IN_H * CHANNELS;
  localparam int XW = $clog2(IN_W);
  localparam int YW = $clog2(IN_H);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PROC, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [AIN_W-1:0]  r_load;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_r;
  logic [CW-1:0]     r_c;

  logic              w_load_last;
  logic              w_last_x;
  logic              w_last_r;
  logic              w_last_c;
  logic [1:0]        w_rc;
  logic [1:0]        w_cc;
  logic [AIN_W-1:0]  w_ain_proc;
  logic [AOUT_W-1:0] w_aout_proc;

  assign w_load_last = (r_load == AIN_W'(N - 1));
  assign w_last_x    = (r_x == XW'(IN_W - 1));
  assign w_last_r    = (r_r == YW'(IN_H - 1));
  assign w_last_c    = (r_c == CW'(CHANNELS - 1));

  assign w_ain_proc  = AIN_W'(32'(r_c) * 32'(IN_W * IN_H) + 32'(r_r) * 32'(IN_W) + 32'(r_x));
  assign w_aout_proc = AOUT_W'(32'(r_c) * 32'(4 * IN_W * IN_H) + 32'(r_r) * 32'(4 * IN_W)
                               + 32'(r_x) * 32'd2);

  assign w_rc = (r_r == '0) ? 2'd0 : (w_last_r ? 2'd2 : 2'd1);
  assign w_cc = (r_x == '0) ? 2'd0 : (w_last_x ? 2'd2 : 2'd1);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    en_write_in  = 1'b0;
    en_write_out = 1'b0;
    addr_input   = '0;
    addr_output  = '0;
    write_mode   = '0;
    ch_idx       = '0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) w_next = S_LOAD;
      end
      S_LOAD: begin
        busy        = 1'b1;
        en_write_in = load_valid;
        addr_input  = r_load;
        if (abort)                          w_next = S_IDLE;
        else if (load_valid && w_load_last) w_next = S_PROC;
      end
      S_PROC: begin
        busy         = 1'b1;
        en_write_out = out_ready;
        addr_input   = w_ain_proc;
        addr_output  = w_aout_proc;
        write_mode   = {2'b00, w_rc} * 4'd3 + {2'b00, w_cc};
        ch_idx       = r_c;
        if (abort)                                              w_next = S_IDLE;
        else if (out_ready && w_last_x && w_last_r && w_last_c) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Counters are held at zero outside LOAD/PROC, so every job starts clean.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_load <= '0;
      r_x    <= '0;
      r_r    <= '0;
      r_c    <= '0;
    end else if (abort || r_state == S_IDLE || r_state == S_DONE) begin
      r_load <= '0;
      r_x    <= '0;
      r_r    <= '0;
      r_c    <= '0;
    end else if (r_state == S_LOAD) begin
      if (load_valid) r_load <= w_load_last ? '0 : r_load + AIN_W'(1);
    end else if (r_state == S_PROC && out_ready) begin
      if (w_last_x) begin
        r_x <= '0;
        if (w_last_r) begin
          r_r <= '0;
          r_c <= w_last_c ? '0 : r_c + CW'(1);
        end else begin
          r_r <= r_r + YW'(1);
        end
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

endmodule

// File: tb/tb_upsample2x_addr_ctrl.sv
// Bench for upsample2x_addr_ctrl (4x4x2): cycle-level reference model driven by
// beat/write indices, directed scenarios plus randomized flow control, abort and reset.
module tb_upsample2x_addr_ctrl;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CH = 2;
  localparam int N  = W * H * CH;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       load_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       en_write_in;
  logic       en_write_out;
  logic [5:0] addr_input;
  logic [7:0] addr_output;
  logic [3:0] write_mode;
  logic [0:0] ch_idx;

  upsample2x_addr_ctrl #(
    .IN_W(W), .IN_H(H), .CHANNELS(CH), .AIN_W(6), .AOUT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .load_valid(load_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .en_write_in(en_write_in), .en_write_out(en_write_out),
    .addr_input(addr_input), .addr_output(addr_output),
    .write_mode(write_mode), .ch_idx(ch_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0 idle, 1 load, 2 process, 3 done; k = load beat / pixel write index.
  int m_phase = 0;
  int m_k     = 0;
  bit m_valid = 1'b0;

  int job_cyc, n_ein, dut_wr, n_done, done_cyc;
  bit cp_en     = 1'b0;
  bit stall_chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int mode_of(input int p);
    int x, r, rc, cc;
    x  = p % W;
    r  = (p / W) % H;
    rc = (r == 0) ? 0 : ((r == H - 1) ? 2 : 1);
    cc = (x == 0) ? 0 : ((x == W - 1) ? 2 : 1);
    return 3 * rc + cc;
  endfunction

  function automatic int out_of(input int p);
    int c, r, x;
    c = p / (W * H);
    r = (p / W) % H;
    x = p % W;
    return c * 4 * W * H + 2 * r * (2 * W) + 2 * x;
  endfunction

  function automatic bit pick(input int m, input int i);
    if (m == 0) return 1'b1;
    if (m == 1) return (i % 2) == 1;
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic step(input bit st, input bit ab, input bit lv, input bit ordy, input bit rs);
    @(negedge clk);
    start = st; abort = ab; load_valid = lv; out_ready = ordy; rst = rs;
    #1;
    if (m_valid) begin
      check("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
      check("done", 32'(done), 32'(m_phase == 3));
      check("en_in", 32'(en_write_in), 32'(m_phase == 1 && lv));
      check("en_out", 32'(en_write_out), 32'(m_phase == 2 && ordy));
      check("addr_in", 32'(addr_input), (m_phase == 1 || m_phase == 2) ? m_k : 0);
      check("addr_out", 32'(addr_output), (m_phase == 2) ? out_of(m_k) : 0);
      check("mode", 32'(write_mode), (m_phase == 2) ? mode_of(m_k) : 0);
      check("ch_idx", 32'(ch_idx), (m_phase == 2) ? m_k / (W * H) : 0);
      if (stall_chk) begin
        check("stall_ain", 32'(addr_input), 9);
        check("stall_aout", 32'(addr_output), 34);
        check("stall_mode", 32'(write_mode), 4);
      end
      if (en_write_in) n_ein++;
      if (en_write_out) begin
        if (cp_en && dut_wr == 0) begin
          check("cp0_in", 32'(addr_input), 0);
          check("cp0_out", 32'(addr_output), 0);
          check("cp0_mode", 32'(write_mode), 0);
        end
        if (cp_en && dut_wr == 7) begin
          check("cp7_in", 32'(addr_input), 7);
          check("cp7_out", 32'(addr_output), 22);
          check("cp7_mode", 32'(write_mode), 5);
        end
        if (cp_en && dut_wr == 31) begin
          check("cp31_in", 32'(addr_input), 31);
          check("cp31_out", 32'(addr_output), 118);
          check("cp31_mode", 32'(write_mode), 8);
        end
        dut_wr++;
      end
      if (done) begin
        n_done++;
        done_cyc = job_cyc;
      end
    end
    @(posedge clk);
    job_cyc++;
    if (!rs) begin
      m_phase = 0; m_k = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_phase)
        0: if (st && !ab) begin m_phase = 1; m_k = 0; end
        1: if (ab) begin m_phase = 0; m_k = 0; end
           else if (lv) begin
             if (m_k == N - 1) begin m_phase = 2; m_k = 0; end
             else m_k++;
           end
        2: if (ab) begin m_phase = 0; m_k = 0; end
           else if (ordy) begin
             if (m_k == N - 1) m_phase = 3;
             else m_k++;
           end
        default: begin m_phase = 0; m_k = 0; end
      endcase
    end
  endtask

  task automatic clear_job_stats();
    job_cyc = 0; n_ein = 0; dut_wr = 0; n_done = 0; done_cyc = -1;
  endtask

  task automatic run_job(input int lvm, input int orm, input bit start_noise);
    int i;
    clear_job_stats();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    i = 1;
    while (m_phase != 0 && i < 600) begin
      step(start_noise ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, pick(lvm, i), pick(orm, i), 1'b1);
      i++;
    end
    check("job_timeout", m_phase, 0);
  endtask

  initial begin
    bit stalled;
    int i;
    start = 0; abort = 0; load_valid = 0; out_ready = 0; rst = 0;

    // Reset then idle with start low
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (6) step(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), 1);

    // Full job, continuous flow, with spec checkpoints
    cp_en = 1'b1;
    run_job(0, 0, 1'b0);
    cp_en = 1'b0;
    check("full_ein", n_ein, N);
    check("full_writes", dut_wr, N);
    check("full_done_cnt", n_done, 1);
    check("full_done_cyc", done_cyc, 1 + N + N);

    // Load gaps
    run_job(1, 0, 1'b0);
    check("gap_ein", n_ein, N);
    check("gap_done_cnt", n_done, 1);

    // Backpressure at pixel 9 (c0,r2,x1)
    clear_job_stats();
    stalled = 1'b0;
    step(1, 0, 0, 0, 1);
    i = 0;
    while (m_phase != 0 && i < 200) begin
      if (m_phase == 2 && m_k == 9 && !stalled) begin
        stall_chk = 1'b1;
        repeat (3) step(0, 0, 1, 0, 1);
        stall_chk = 1'b0;
        stalled = 1'b1;
      end else begin
        step(0, 0, 1, 1, 1);
      end
      i++;
    end
    check("bp_timeout", m_phase, 0);
    check("bp_writes", dut_wr, N);
    check("bp_done_cyc", done_cyc, 1 + N + N + 3);

    // Abort mid-PROC, then a clean job
    clear_job_stats();
    step(1, 0, 0, 0, 1);
    i = 0;
    while (!(m_phase == 2 && m_k == 5) && i < 200) begin
      step(0, 0, 1, 1, 1);
      i++;
    end
    step(0, 1, 1, 1, 1);
    repeat (3) step(0, 0, 1, 1, 1);
    check("abort_done_cnt", n_done, 0);
    run_job(0, 0, 1'b0);
    check("restart_ein", n_ein, N);
    check("restart_done_cnt", n_done, 1);

    // Reset during LOAD
    clear_job_stats();
    step(1, 0, 0, 0, 1);
    repeat (10) step(0, 0, 1, 1, 1);
    step(0, 0, 1, 1, 0);
    repeat (3) step(0, 0, 1, 1, 1);
    check("rst_done_cnt", n_done, 0);

    // start toggling while busy must not disturb timing
    run_job(0, 0, 1'b1);
    check("sbusy_done_cnt", n_done, 1);
    check("sbusy_done_cyc", done_cyc, 1 + N + N);

    // Randomized flow control with rare abort, start noise and reset
    for (int j = 0; j < 40; j++) begin
      int lvm, orm, c;
      lvm = $urandom_range(0, 2);
      orm = $urandom_range(0, 2);
      clear_job_stats();
      step(1, $urandom_range(0, 9) == 0, 0, 0, 1);
      c = 0;
      while (m_phase != 0 && c < 600) begin
        step($urandom_range(0, 1), $urandom_range(0, 149) == 0,
             pick(lvm, c), pick(orm, c), $urandom_range(0, 399) != 0);
        c++;
      end
      check("rand_timeout", m_phase, 0);
      repeat ($urandom_range(0, 3)) step(0, $urandom_range(0, 1), 0, 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/upsample2x_addr_ctrl.md
Name: upsample2x_addr_ctrl

Overview:
- Parametrised control unit for the 2x nearest/bilinear upsampling datapath.
- Sequences a load phase that fills the input feature buffer, then a process phase that walks every input pixel of every channel.
- Per pixel it drives the input read address, the output base address of the 2x2 destination block, and a 9-way border-region write_mode.
- Generalises the fixed 4x4 single-channel controller to IN_W x IN_H x CHANNELS, with output backpressure, load flow control and abort.

Parameters:
- IN_W, 4, input image width in pixels; must be >= 2.
- IN_H, 4, input image height in pixels; must be >= 2.
- CHANNELS, 1, number of channel planes processed back-to-back; must be >= 1.
- AIN_W, 6, input address width; must hold IN_W*IN_H*CHANNELS-1.
- AOUT_W, 8, output address width; must hold 4*IN_W*IN_H*CHANNELS-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- start  in  1  begin a job; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE next cycle without a done pulse.
- load_valid  in  1  input sample is present on the loader bus this cycle.
- out_ready  in  1  output buffer/datapath accepts a write this cycle.
- busy  out  1  high in LOAD and PROC.
- done  out  1  one-cycle pulse at job completion.
- en_write_in  out  1  input buffer write enable.
- en_write_out  out  1  output buffer write enable.
- addr_input  out  AIN_W  input buffer address (write in LOAD, read in PROC).
- addr_output  out  AOUT_W  output address of the top-left pixel of the 2x2 block.
- write_mode  out  4  border region code, 0..8.
- ch_idx  out  max(1,clog2(CHANNELS))  current channel in PROC.

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE, all counters 0. All outputs 0. This applies mid-job too.
- Outputs are combinational decodes of registered state and counters. Address and enables are valid in the same cycle; zero latency.
- State IDLE:
  - All outputs 0.
  - start=1 -> LOAD. Counters are cleared on entry.
- State LOAD:
  - en_write_in = load_valid.
  - addr_input = load counter L, ranging 0..N-1 where N = IN_W*IN_H*CHANNELS.
  - L increments only on cycles with load_valid=1.
  - When load_valid=1 and L=N-1 -> PROC, with pixel counters cleared.
- State PROC:
  - Nested counters: x (column, innermost), r (row), c (channel, outermost).
  - addr_input = c*IN_W*IN_H + r*IN_W + x.
  - addr_output = c*4*IN_W*IN_H + 2r*(2*IN_W) + 2x.
  - ch_idx = c.
  - en_write_out = out_ready.
  - Counters advance only when out_ready=1. While out_ready=0, every output holds its value.
  - x wraps at IN_W-1 and increments r. r wraps at IN_H-1 and increments c.
  - On the write of x=IN_W-1, r=IN_H-1, c=CHANNELS-1 -> DONE.
- State DONE:
  - done=1 for exactly one cycle; all enables 0 -> IDLE.
- write_mode = 3*rc + cc.
  - rc = 0 if r=0, 2 if r=IN_H-1, else 1.
  - cc = 0 if x=0, 2 if x=IN_W-1, else 1.
  - Resulting codes: 0 top-left, 1 top, 2 top-right, 3 left, 4 centre, 5 right, 6 bottom-left, 7 bottom, 8 bottom-right.
  - write_mode=0 outside PROC.
- Arithmetic: all address math is unsigned and truncated to the port width. The parameter constraints guarantee no overflow.
- start while busy is ignored.
- abort=1 in LOAD/PROC/DONE -> IDLE next cycle, counters cleared, no done pulse.
- abort has priority over the state transition of the same cycle. rst has priority over abort.
- start and abort both high in IDLE: stay IDLE.
- Job cycle count with load_valid=out_ready=1 throughout: 1 (IDLE->LOAD) + N (LOAD) + N (PROC) + 1 (DONE).

Test Plan:
- Reset/idle: rst=0 for 2 cycles, then 1 with start=0 -> all outputs 0, busy=0 indefinitely.
- Full job, IN_W=IN_H=4, CHANNELS=2, load_valid=out_ready=1:
  - 32 en_write_in pulses with addr_input 0..31, then 32 en_write_out writes.
  - Check points (first to last write): (c0,r0,x0) -> in 0, out 0, mode 0. (c0,r1,x3) -> in 7, out 22, mode 5. (c1,r3,x3) -> in 31, out 118, mode 8.
  - done pulses once, exactly 1 cycle after the last write.
- Load gaps: load_valid toggling 1,0,1,0 -> addr_input advances only on valid cycles, en_write_in=0 on gap cycles, PROC entered after the 32nd valid beat.
- Backpressure: out_ready=0 for 3 cycles at (c0,r2,x1) -> addr_input=9, addr_output=34, write_mode=4 held, en_write_out=0. Resumes at x=2 after out_ready returns to 1.
- Abort/restart: abort=1 mid-PROC -> IDLE next cycle, no done, busy=0. A following start runs a full clean job from addr_input 0.
- Reset mid-job and start-while-busy: rst=0 during LOAD -> all outputs 0 next cycle. start pulsed during PROC -> no effect on counters or done timing.
